// File: rtl/wb_pkg.sv
// Shared types for the register-file writeback path.
// Register-value width, register addressing and the queued result bundle.
package wb_pkg;

   localparam int unsigned XLEN   = 32;
   localparam int unsigned REG_AW = 5;
   localparam int unsigned NREGS  = 32;

   typedef struct packed {
      logic [REG_AW-1:0] rd;
      logic [XLEN-1:0]   data;
   } wb_req_t;

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO holding out-of-order long-latency results.
// Head is read combinationally; no write-to-read bypass.
module wb_fifo
   import wb_pkg::*;
#(
   parameter  int unsigned DEPTH = 4,
   localparam int unsigned AW    = $clog2(DEPTH),
   localparam int unsigned CW    = AW + 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push_i,
   input  wb_req_t       data_i,
   input  logic          pop_i,
   output wb_req_t       head_o,
   output logic          full_o,
   output logic          empty_o,
   output logic [CW-1:0] count_o
);

   wb_req_t       mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          do_push, do_pop;

   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign head_o  = mem_q[rd_ptr_q];

   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;

   // Power-of-two depth lets the pointers wrap by overflow.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CW'(do_push) - CW'(do_pop);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= data_i;
   end

endmodule

// File: rtl/writeback_arbiter.sv
// Register-file write port arbiter: pipeline results win over queued
// long-latency results; keeps the busy scoreboard used for decode stalls.
module writeback_arbiter
   import wb_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              pipe_valid,
   input  logic [REG_AW-1:0] pipe_rd,
   input  logic [XLEN-1:0]   pipe_data,
   input  logic              lu_valid,
   input  logic [REG_AW-1:0] lu_rd,
   input  logic [XLEN-1:0]   lu_data,
   output logic              lu_ready,
   input  logic              iss_valid,
   input  logic [REG_AW-1:0] iss_rd,
   input  logic [REG_AW-1:0] q_rs1,
   input  logic [REG_AW-1:0] q_rs2,
   input  logic [REG_AW-1:0] q_rd,
   output logic              hazard,
   output logic              reg_write,
   output logic [REG_AW-1:0] wb_rd,
   output logic [XLEN-1:0]   wb_data,
   output logic [NREGS-1:0]  busy
);

   localparam int unsigned CW = $clog2(DEPTH) + 1;

   wb_req_t           fifo_head, fifo_in;
   logic              fifo_full, fifo_empty;
   logic [CW-1:0]     fifo_count;
   logic              fifo_push, pipe_sel, fifo_sel;

   logic              we_q, we_d;
   logic [REG_AW-1:0] rd_q, rd_d;
   logic [XLEN-1:0]   data_q, data_d;
   logic [NREGS-1:0]  busy_q, busy_d;

   assign lu_ready  = (fifo_count != CW'(DEPTH));
   // rd=0 results complete the handshake but are never queued.
   assign fifo_push = lu_valid && lu_ready && (lu_rd != '0);
   assign fifo_in   = '{rd: lu_rd, data: lu_data};

   assign pipe_sel = pipe_valid && (pipe_rd != '0);
   assign fifo_sel = !pipe_sel && !fifo_empty;

   wb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (fifo_push),
      .data_i  (fifo_in),
      .pop_i   (fifo_sel),
      .head_o  (fifo_head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   always_comb begin
      we_d   = 1'b0;
      rd_d   = rd_q;
      data_d = data_q;
      busy_d = busy_q;
      unique case (1'b1)
         pipe_sel: begin
            we_d   = 1'b1;
            rd_d   = pipe_rd;
            data_d = pipe_data;
         end
         fifo_sel: begin
            we_d   = 1'b1;
            rd_d   = fifo_head.rd;
            data_d = fifo_head.data;
            busy_d[fifo_head.rd] = 1'b0;
         end
         default: ;
      endcase
      // Issue after retire so a same-cycle set wins.
      if (iss_valid && (iss_rd != '0)) busy_d[iss_rd] = 1'b1;
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         we_q   <= 1'b0;
         rd_q   <= '0;
         data_q <= '0;
         busy_q <= '0;
      end else begin
         we_q   <= we_d;
         rd_q   <= rd_d;
         data_q <= data_d;
         busy_q <= busy_d;
      end
   end

   assign hazard    = busy_q[q_rs1] | busy_q[q_rs2] | busy_q[q_rd];
   assign reg_write = we_q;
   assign wb_rd     = rd_q;
   assign wb_data   = data_q;
   assign busy      = busy_q;

   logic unused_full;
   assign unused_full = fifo_full;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed and random stimulus against a queue-based writeback model.
module tb_writeback_arbiter;
   import wb_pkg::*;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        pipe_valid = 0, lu_valid = 0, iss_valid = 0;
   logic [4:0]  pipe_rd = 0, lu_rd = 0, iss_rd = 0;
   logic [4:0]  q_rs1 = 0, q_rs2 = 0, q_rd = 0;
   logic [31:0] pipe_data = 0, lu_data = 0;
   logic        lu_ready, hazard, reg_write;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data, busy;

   writeback_arbiter #(.DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n),
      .pipe_valid(pipe_valid), .pipe_rd(pipe_rd), .pipe_data(pipe_data),
      .lu_valid(lu_valid), .lu_rd(lu_rd), .lu_data(lu_data),
      .lu_ready(lu_ready),
      .iss_valid(iss_valid), .iss_rd(iss_rd),
      .q_rs1(q_rs1), .q_rs2(q_rs2), .q_rd(q_rd),
      .hazard(hazard), .reg_write(reg_write),
      .wb_rd(wb_rd), .wb_data(wb_data), .busy(busy)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // Reference model: results queue, busy set, last written pair.
   wb_req_t     m_q[$];
   bit [31:0]   m_busy;
   bit          m_we;
   bit [4:0]    m_rd;
   bit [31:0]   m_data;

   function automatic void m_reset();
      m_q.delete();
      m_busy = 0;
      m_we   = 0;
      m_rd   = 0;
      m_data = 0;
   endfunction

   // One clock: check combinational outputs, advance model, check registers.
   task automatic cycle();
      bit       rdy;
      bit       hz;
      wb_req_t  h;
      #1;
      rdy = (m_q.size() != DEPTH);
      hz  = m_busy[q_rs1] | m_busy[q_rs2] | m_busy[q_rd];
      chk("lu_ready", lu_ready, rdy);
      chk("hazard", hazard, hz);
      m_we = 0;
      if (pipe_valid && pipe_rd != 0) begin
         m_we = 1; m_rd = pipe_rd; m_data = pipe_data;
      end else if (m_q.size() > 0) begin
         h = m_q.pop_front();
         m_we = 1; m_rd = h.rd; m_data = h.data;
         m_busy[h.rd] = 0;
      end
      if (lu_valid && rdy && lu_rd != 0) m_q.push_back('{rd: lu_rd, data: lu_data});
      if (iss_valid && iss_rd != 0) m_busy[iss_rd] = 1;
      @(posedge clk);
      #1;
      chk("reg_write", reg_write, m_we);
      chk("wb_rd", wb_rd, m_rd);
      chk("wb_data", wb_data, m_data);
      chk("busy", busy, m_busy);
      @(negedge clk);
   endtask

   task automatic idle();
      pipe_valid = 0; lu_valid = 0; iss_valid = 0;
   endtask

   initial begin
      m_reset();
      repeat (2) @(negedge clk);
      rst_n = 1;
      #1;
      chk("rst_lu_ready", lu_ready, 1);
      chk("rst_reg_write", reg_write, 0);
      chk("rst_busy", busy, 0);
      @(negedge clk);

      // Pipeline write, one-cycle latency.
      pipe_valid = 1; pipe_rd = 5; pipe_data = 32'hDEADBEEF;
      cycle();
      idle();
      chk("pipe_we", reg_write, 1);
      chk("pipe_rd", wb_rd, 5);
      chk("pipe_data", wb_data, 32'hDEADBEEF);
      cycle();

      // Issue rd=7, return it through the FIFO.
      iss_valid = 1; iss_rd = 7;
      cycle();
      idle();
      chk("busy7_set", busy[7], 1);
      q_rs1 = 7;
      #1 chk("hazard_rs1", hazard, 1);
      q_rs1 = 0;
      lu_valid = 1; lu_rd = 7; lu_data = 32'h12;
      cycle();
      idle();
      chk("lu_not_yet", reg_write, 0);
      cycle();
      chk("lu_we", reg_write, 1);
      chk("lu_rd", wb_rd, 7);
      chk("lu_data", wb_data, 32'h12);
      chk("busy7_clr", busy[7], 0);

      // Contention: pipeline keeps winning for four cycles.
      lu_valid = 1; lu_rd = 3; lu_data = 32'h33;
      for (int i = 1; i <= 4; i++) begin
         pipe_valid = 1; pipe_rd = 5'(i); pipe_data = 32'h100 + i;
         cycle();
         lu_valid = 0;
         chk("cont_pipe", wb_rd, 5'(i));
      end
      idle();
      cycle();
      chk("cont_fifo_rd", wb_rd, 3);
      chk("cont_fifo_data", wb_data, 32'h33);

      // Fill the FIFO while the pipeline saturates.
      for (int i = 0; i < 5; i++) begin
         pipe_valid = 1; pipe_rd = 1; pipe_data = i;
         lu_valid = 1; lu_rd = 5'(10 + i); lu_data = 32'hA0 + i;
         if (i == 4) begin
            #1 chk("full_ready", lu_ready, 0);
         end
         cycle();
      end
      idle();
      for (int i = 0; i < 4; i++) begin
         cycle();
         chk("drain_rd", wb_rd, 5'(10 + i));
         chk("drain_data", wb_data, 32'hA0 + i);
      end

      // rd=0 pipeline drop; set beats clear on the same edge.
      iss_valid = 1; iss_rd = 9;
      cycle();
      idle();
      lu_valid = 1; lu_rd = 9; lu_data = 32'h99;
      cycle();
      idle();
      pipe_valid = 1; pipe_rd = 0; pipe_data = 32'hFFFF;
      iss_valid = 1; iss_rd = 9;
      cycle();
      idle();
      chk("rd0_pop_rd", wb_rd, 9);
      chk("set_wins", busy[9], 1);
      q_rs2 = 0; q_rs1 = 2; q_rd = 4;
      #1 chk("rs2_zero", hazard, 0);
      q_rs1 = 0; q_rd = 0;

      // Reset with three queued entries.
      for (int i = 0; i < 3; i++) begin
         pipe_valid = 1; pipe_rd = 2; pipe_data = i;
         lu_valid = 1; lu_rd = 5'(20 + i); lu_data = i;
         iss_valid = 1; iss_rd = 5'(20 + i);
         cycle();
      end
      idle();
      #2 rst_n = 0;
      m_reset();
      #1;
      chk("mid_rst_we", reg_write, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_ready", lu_ready, 1);
      chk("mid_rst_data", wb_data, 0);
      @(negedge clk);
      rst_n = 1;
      @(negedge clk);

      // Random traffic.
      for (int n = 0; n < 400; n++) begin
         pipe_valid = ($urandom_range(0, 2) == 0);
         pipe_rd    = 5'($urandom);
         pipe_data  = $urandom;
         lu_valid   = $urandom_range(0, 1);
         lu_rd      = 5'($urandom);
         lu_data    = $urandom;
         iss_valid  = $urandom_range(0, 1);
         iss_rd     = 5'($urandom);
         q_rs1      = 5'($urandom);
         q_rs2      = 5'($urandom);
         q_rd       = 5'($urandom);
         cycle();
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
